std_cache_axi_mux: RTL and testbench
====================================

Name: std_cache_axi_mux

Overview:
- Parametrised N-to-1 AXI4 multiplexer that merges the L1 cache-side masters onto the single core AXI master port: I$, D$ refill/writeback, D$ bypass, and any further cache agents.
- Generalises the fixed 3-input, fixed-ID arbitration scheme. The master index is prepended to each transaction ID instead of decoding hard-coded ID patterns.
- Adds round-robin AR/AW arbitration, a configurable W-ordering FIFO depth, and an outstanding-write limit.
- Sits between the cache subsystem's internal masters and the core AXI port.

Parameters:
- NumPorts, 3, number of slave-side (cache) masters, 2..8
- SlvIdWidth, 4, AXI ID width on each input port
- MaxWTrans, 4, max accepted AW bursts whose W data is not yet complete, power of 2, >=2
- slv_req_t / slv_rsp_t, logic, AXI request/response structs with SlvIdWidth IDs
- mst_req_t / mst_rsp_t, logic, AXI structs with ID width SlvIdWidth+IdxW, IdxW = max(1,$clog2(NumPorts))

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- slv_req_i  in  NumPorts x slv_req_t  requests from cache masters
- slv_rsp_o  out  NumPorts x slv_rsp_t  responses to cache masters
- mst_req_o  out  mst_req_t  merged request to core AXI port
- mst_rsp_i  in  mst_rsp_t  response from core AXI port
- route_err_o  out  1  pulse: R/B beat carried an ID prefix >= NumPorts
- aw_stall_cnt_o  out  NumPorts x 16  per-port AW stall counters (see Optional Feature)

Behaviour:
- Reset: all valid/ready outputs 0, RR pointers 0, W FIFO empty, outstanding counter 0, route_err_o 0, counters 0.
- AR channel:
  - Round-robin arbiter over ar_valid, zero-cycle latency.
  - Once valid is asserted toward the master, the grant is locked until ar_ready, so AR payload stays stable per AXI.
  - Pointer advances to (winner+1) mod NumPorts on handshake only.
  - mst ar.id = {winner_idx, slv ar.id}.
- AW channel:
  - Same arbitration and ID prefixing as AR.
  - Output aw_valid additionally gated by !w_fifo_full && outstanding < MaxWTrans.
  - Gating is applied before lock, so valid never drops once raised.
  - On AW handshake: push winner_idx into W FIFO (depth MaxWTrans) and increment outstanding.
- W channel:
  - Selection = FIFO head.
  - If FIFO empty and an AW handshake occurs in the same cycle: fall-through, W is selected from the AW winner that cycle.
  - If FIFO empty with no AW handshake: mst w_valid=0 and all slave w_ready=0.
  - On a W handshake with w.last: pop FIFO and decrement outstanding.
  - Simultaneous push and pop: counter unchanged.
  - W beats are never accepted ahead of their AW.
- R/B channels:
  - Route by id[top IdxW bits]; strip the prefix back to SlvIdWidth.
  - Only the addressed slave sees valid; mst ready = that slave's ready.
  - Prefix >= NumPorts: beat is consumed (ready=1), no slave valid, route_err_o=1 for that cycle.
- No internal buffering on R/B: combinational pass-through.
- Reset mid-burst: all state cleared immediately (async); no completion of in-flight beats is attempted.

Optional Feature:
- Macro: STD_CACHE_AXI_MUX_PERF_EN.
- Defined: aw_stall_cnt_o[i] increments each cycle port i has aw_valid=1 without an AW handshake; saturates at 16'hFFFF; cleared by reset only.
- Undefined: the port remains present, tied to 0, and no counter flops are synthesised.

Test Plan:
- NumPorts=3, ports 0/1/2 assert ar_valid continuously, ar_ready=1 -> grants 0,1,2,0,1,2; mst ar.id = {2'd0,4'h0},{2'd1,..},{2'd2,..}.
- Port 1 ar_valid held, mst ar_ready=0 for 5 cycles while port 0 raises ar_valid -> grant stays port 1, payload stable, port 0 granted after handshake.
- Back-to-back AW from port 2 (4 beats) then port 0 (1 beat), W from port 0 presented early -> port 0 W stalled (w_ready=0) until port 2's 4th beat with last; FIFO order 2,0.
- MaxWTrans=4, 4 AWs accepted, W withheld -> 5th aw_valid not forwarded; one W last accepted -> 5th AW issued next cycle.
- R beat id={2'd3,4'h5} with NumPorts=3 -> r_ready=1, no slave r_valid, route_err_o=1 one cycle; R id={2'd1,4'h5} -> port 1 r_valid, r.id=4'h5.
- With STD_CACHE_AXI_MUX_PERF_EN, port 0 aw_valid held 10 cycles with aw_ready=0 -> aw_stall_cnt_o[0]=10; assert rst_i mid-test -> counter, FIFO and valids 0 immediately.

Source files
------------

// File: rtl/std_cache_axi_mux.sv
// std_cache_axi_mux
//
// Merges NumPorts cache-side AXI4 masters (I$, D$ refill/writeback, D$
// bypass, ...) onto the single core AXI master port.
//
//   AR/AW : round-robin arbitration, zero-cycle latency. The winner's index
//           is prepended to its ID, so mst id = {port_idx, slv id}. Once a
//           master-side valid is raised the grant is held until the handshake.
//           AW is also held off while the W-order FIFO is full or MaxWTrans
//           bursts are still waiting for their W data.
//   W     : served in AW order from a FIFO of port indices. When the FIFO
//           is empty, the port whose AW is accepted in the same cycle may
//           stream W straight through.
//   R/B   : combinational pass-through, routed on the ID prefix, which is
//           stripped before it reaches the slave port. A prefix >= NumPorts
//           is consumed and flagged on route_err_o.
//
// Handshake rule on every channel: a beat transfers in the cycle where
// valid and ready are both 1; a raised valid and its payload stay stable
// until that cycle; ready may depend combinationally on valid.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous, active-high reset
//   slv_req_i[N]    requests from the cache masters
//   slv_rsp_o[N]    responses to the cache masters
//   mst_req_o       merged request to the core AXI port
//   mst_rsp_i       response from the core AXI port
//   route_err_o     1 in a cycle where an R/B beat has an ID prefix >= NumPorts
//   aw_stall_cnt_o  per-port count of cycles with aw_valid and no AW handshake
//
// Optional feature macro: STD_CACHE_AXI_MUX_PERF_EN enables the AW stall
// counters (16 bit, saturating). Without it aw_stall_cnt_o is tied to 0.
//
// The request/response struct types must carry aw/ar (id, addr, len, size,
// burst, cache, prot), w, b (id, resp) and r (id, data, resp, last) fields.

package std_cache_axi_mux_pkg;
  localparam int unsigned AddrWidth  = 32;
  localparam int unsigned DataWidth  = 32;
  localparam int unsigned SlvIdWidth = 4;
  localparam int unsigned MstIdWidth = 6;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } slv_ax_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [AddrWidth-1:0]  addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } mst_ax_t;

  typedef struct packed {
    logic [DataWidth-1:0]   data;
    logic [DataWidth/8-1:0] strb;
    logic                   last;
  } w_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [1:0]            resp;
  } slv_b_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [1:0]            resp;
  } mst_b_t;

  typedef struct packed {
    logic [SlvIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } slv_r_t;

  typedef struct packed {
    logic [MstIdWidth-1:0] id;
    logic [DataWidth-1:0]  data;
    logic [1:0]            resp;
    logic                  last;
  } mst_r_t;

  typedef struct packed {
    slv_ax_t aw;
    logic    aw_valid;
    w_t      w;
    logic    w_valid;
    logic    b_ready;
    slv_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } slv_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    slv_b_t b;
    logic   b_valid;
    slv_r_t r;
    logic   r_valid;
  } slv_rsp_t;

  typedef struct packed {
    mst_ax_t aw;
    logic    aw_valid;
    w_t      w;
    logic    w_valid;
    logic    b_ready;
    mst_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } mst_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    mst_b_t b;
    logic   b_valid;
    mst_r_t r;
    logic   r_valid;
  } mst_rsp_t;
endpackage

module std_cache_axi_mux #(
  parameter int unsigned NumPorts   = 3,
  parameter int unsigned SlvIdWidth = 4,
  parameter int unsigned MaxWTrans  = 4,
  parameter type slv_req_t = std_cache_axi_mux_pkg::slv_req_t,
  parameter type slv_rsp_t = std_cache_axi_mux_pkg::slv_rsp_t,
  parameter type mst_req_t = std_cache_axi_mux_pkg::mst_req_t,
  parameter type mst_rsp_t = std_cache_axi_mux_pkg::mst_rsp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  slv_req_t [NumPorts-1:0]    slv_req_i,
  output slv_rsp_t [NumPorts-1:0]    slv_rsp_o,
  output mst_req_t                   mst_req_o,
  input  mst_rsp_t                   mst_rsp_i,
  output logic                       route_err_o,
  output logic [NumPorts-1:0][15:0]  aw_stall_cnt_o
);

  localparam int unsigned IdxW       = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  localparam int unsigned MstIdWidth = SlvIdWidth + IdxW;
  localparam int unsigned PtrW       = $clog2(MaxWTrans);
  localparam int unsigned CntW       = PtrW + 1;

  typedef logic [IdxW-1:0] idx_t;

  // First requester at or after ptr; MSB of the result is "any request".
  function automatic logic [IdxW:0] rr_pick(input logic [NumPorts-1:0] req, input idx_t ptr);
    logic [IdxW:0] res;
    idx_t          p;
    res = '0;
    for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
      p = idx_t'((32'(ptr) + 32'(k)) % NumPorts);
      if (req[p]) res = {1'b1, p};
    end
    return res;
  endfunction

  function automatic idx_t rr_next(input idx_t w);
    return (32'(w) + 32'd1 == NumPorts) ? '0 : idx_t'(w + 1'b1);
  endfunction

  // Arbitration / W-order state
  idx_t            ar_ptr_q, aw_ptr_q;
  logic            ar_lock_q, aw_lock_q;
  idx_t            ar_lock_idx_q, aw_lock_idx_q;
  idx_t            fifo_q [MaxWTrans];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] fifo_cnt_q, out_cnt_q;

  logic [NumPorts-1:0] ar_req, aw_req, w_req;
  logic [IdxW:0]       ar_pick, aw_pick;
  idx_t                ar_sel, aw_sel, w_sel;
  logic                ar_valid, aw_valid, aw_gate, w_active, w_valid, w_last;
  logic                ar_hs, aw_hs, w_last_hs;
  logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
  idx_t                r_pfx, b_pfx;
  logic                r_bad, b_bad;

  always_comb begin
    for (int i = 0; i < int'(NumPorts); i++) begin
      ar_req[i] = slv_req_i[i].ar_valid;
      aw_req[i] = slv_req_i[i].aw_valid;
      w_req[i]  = slv_req_i[i].w_valid;
    end
    ar_pick    = rr_pick(ar_req, ar_ptr_q);
    aw_pick    = rr_pick(aw_req, aw_ptr_q);
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (32'(fifo_cnt_q) == MaxWTrans);
    aw_gate    = !fifo_full && (32'(out_cnt_q) < MaxWTrans);

    // Outputs are forced idle while reset is asserted, even though the
    // slave inputs may still be driving valid.
    ar_sel   = ar_lock_q ? ar_lock_idx_q : ar_pick[IdxW-1:0];
    ar_valid = !rst_i && (ar_lock_q ? ar_req[ar_sel] : ar_pick[IdxW]);
    // The AW gate applies only before the grant locks, so a raised aw_valid
    // is never withdrawn.
    aw_sel   = aw_lock_q ? aw_lock_idx_q : aw_pick[IdxW-1:0];
    aw_valid = !rst_i && (aw_lock_q ? aw_req[aw_sel] : (aw_pick[IdxW] && aw_gate));
    ar_hs    = ar_valid && mst_rsp_i.ar_ready;
    aw_hs    = aw_valid && mst_rsp_i.aw_ready;

    // W follows the FIFO head; with an empty FIFO only the port whose AW is
    // being accepted right now may send W (fall-through).
    if (!fifo_empty) begin
      w_active = !rst_i;
      w_sel    = fifo_q[rd_ptr_q];
    end else begin
      w_active = aw_hs;
      w_sel    = aw_sel;
    end
    w_valid   = w_active && w_req[w_sel];
    w_last    = 1'b0;
    for (int i = 0; i < int'(NumPorts); i++) begin
      if (w_sel == idx_t'(i)) w_last = slv_req_i[i].w.last;
    end
    w_last_hs = w_valid && mst_rsp_i.w_ready && w_last;
    // A single-beat fall-through burst completes in its AW cycle and never
    // occupies the FIFO.
    fifo_push = aw_hs && !(fifo_empty && w_last_hs);
    fifo_pop  = w_last_hs && !fifo_empty;

    r_pfx = mst_rsp_i.r.id[MstIdWidth-1 -: IdxW];
    b_pfx = mst_rsp_i.b.id[MstIdWidth-1 -: IdxW];
    r_bad = (32'(r_pfx) >= NumPorts);
    b_bad = (32'(b_pfx) >= NumPorts);
    route_err_o = (mst_rsp_i.r_valid && r_bad) || (mst_rsp_i.b_valid && b_bad);
  end

  // Master-side request
  always_comb begin
    mst_req_o          = '0;
    mst_req_o.ar_valid = ar_valid;
    mst_req_o.aw_valid = aw_valid;
    mst_req_o.w_valid  = w_valid;
    mst_req_o.r_ready  = r_bad;
    mst_req_o.b_ready  = b_bad;
    for (int i = 0; i < int'(NumPorts); i++) begin
      if (ar_sel == idx_t'(i)) begin
        mst_req_o.ar.id    = {idx_t'(i), slv_req_i[i].ar.id};
        mst_req_o.ar.addr  = slv_req_i[i].ar.addr;
        mst_req_o.ar.len   = slv_req_i[i].ar.len;
        mst_req_o.ar.size  = slv_req_i[i].ar.size;
        mst_req_o.ar.burst = slv_req_i[i].ar.burst;
        mst_req_o.ar.cache = slv_req_i[i].ar.cache;
        mst_req_o.ar.prot  = slv_req_i[i].ar.prot;
      end
      if (aw_sel == idx_t'(i)) begin
        mst_req_o.aw.id    = {idx_t'(i), slv_req_i[i].aw.id};
        mst_req_o.aw.addr  = slv_req_i[i].aw.addr;
        mst_req_o.aw.len   = slv_req_i[i].aw.len;
        mst_req_o.aw.size  = slv_req_i[i].aw.size;
        mst_req_o.aw.burst = slv_req_i[i].aw.burst;
        mst_req_o.aw.cache = slv_req_i[i].aw.cache;
        mst_req_o.aw.prot  = slv_req_i[i].aw.prot;
      end
      if (w_sel == idx_t'(i)) mst_req_o.w = slv_req_i[i].w;
      if (!r_bad && r_pfx == idx_t'(i)) mst_req_o.r_ready = slv_req_i[i].r_ready;
      if (!b_bad && b_pfx == idx_t'(i)) mst_req_o.b_ready = slv_req_i[i].b_ready;
    end
  end

  // Slave-side responses
  always_comb begin
    for (int i = 0; i < int'(NumPorts); i++) begin
      slv_rsp_o[i]          = '0;
      slv_rsp_o[i].ar_ready = ar_hs && (ar_sel == idx_t'(i));
      slv_rsp_o[i].aw_ready = aw_hs && (aw_sel == idx_t'(i));
      slv_rsp_o[i].w_ready  = w_active && mst_rsp_i.w_ready && (w_sel == idx_t'(i));
      slv_rsp_o[i].b.id     = mst_rsp_i.b.id[SlvIdWidth-1:0];
      slv_rsp_o[i].b.resp   = mst_rsp_i.b.resp;
      slv_rsp_o[i].b_valid  = mst_rsp_i.b_valid && !b_bad && (b_pfx == idx_t'(i));
      slv_rsp_o[i].r.id     = mst_rsp_i.r.id[SlvIdWidth-1:0];
      slv_rsp_o[i].r.data   = mst_rsp_i.r.data;
      slv_rsp_o[i].r.resp   = mst_rsp_i.r.resp;
      slv_rsp_o[i].r.last   = mst_rsp_i.r.last;
      slv_rsp_o[i].r_valid  = mst_rsp_i.r_valid && !r_bad && (r_pfx == idx_t'(i));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ar_ptr_q      <= '0;
      aw_ptr_q      <= '0;
      ar_lock_q     <= 1'b0;
      aw_lock_q     <= 1'b0;
      ar_lock_idx_q <= '0;
      aw_lock_idx_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      out_cnt_q     <= '0;
    end else begin
      if (ar_hs) begin
        ar_ptr_q  <= rr_next(ar_sel);
        ar_lock_q <= 1'b0;
      end else if (ar_valid) begin
        ar_lock_q     <= 1'b1;
        ar_lock_idx_q <= ar_sel;
      end
      if (aw_hs) begin
        aw_ptr_q  <= rr_next(aw_sel);
        aw_lock_q <= 1'b0;
      end else if (aw_valid) begin
        aw_lock_q     <= 1'b1;
        aw_lock_idx_q <= aw_sel;
      end
      if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
      case ({aw_hs, w_last_hs})
        2'b10:   out_cnt_q <= out_cnt_q + 1'b1;
        2'b01:   out_cnt_q <= out_cnt_q - 1'b1;
        default: out_cnt_q <= out_cnt_q;
      endcase
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the counters.
  always_ff @(posedge clk_i) begin
    if (fifo_push) fifo_q[wr_ptr_q] <= aw_sel;
  end

`ifdef STD_CACHE_AXI_MUX_PERF_EN
  for (genvar i = 0; i < int'(NumPorts); i++) begin : g_perf
    logic [15:0] stall_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stall_q <= '0;
      end else if (aw_req[i] && !(aw_hs && aw_sel == idx_t'(i)) && stall_q != 16'hFFFF) begin
        stall_q <= stall_q + 16'd1;
      end
    end
    assign aw_stall_cnt_o[i] = stall_q;
  end
`else
  assign aw_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_std_cache_axi_mux.sv
module tb_std_cache_axi_mux;
  import std_cache_axi_mux_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slv_req_t [2:0]       slv_req;
  slv_rsp_t [2:0]       slv_rsp;
  mst_req_t             mst_req;
  mst_rsp_t             mst_rsp;
  logic                 route_err;
  logic [2:0][15:0]     aw_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  std_cache_axi_mux #(
    .NumPorts   (3),
    .SlvIdWidth (4),
    .MaxWTrans  (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .slv_req_i      (slv_req),
    .slv_rsp_o      (slv_rsp),
    .mst_req_o      (mst_req),
    .mst_rsp_i      (mst_rsp),
    .route_err_o    (route_err),
    .aw_stall_cnt_o (aw_stall_cnt)
  );

  // driver tasks
  task automatic clear_inputs();
    slv_req = '0;
    mst_rsp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1;
    n_checks++; if (mst_req.ar_valid !== 1'b0) $display("FAIL reset_ar_valid: got %0b expected 0", mst_req.ar_valid); else n_pass++;
    n_checks++; if (mst_req.aw_valid !== 1'b0) $display("FAIL reset_aw_valid: got %0b expected 0", mst_req.aw_valid); else n_pass++;
    n_checks++; if (mst_req.w_valid !== 1'b0) $display("FAIL reset_w_valid: got %0b expected 0", mst_req.w_valid); else n_pass++;
    n_checks++; if (route_err !== 1'b0) $display("FAIL reset_route_err: got %0b expected 0", route_err); else n_pass++;
    n_checks++; if (aw_stall_cnt !== 48'h0) $display("FAIL reset_stall_cnt: got %0h expected 0", aw_stall_cnt); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ar_rr();
    logic [5:0] exp_id [6];
    int         exp_port [6];
    exp_id   = '{6'h0A, 6'h1B, 6'h2C, 6'h0A, 6'h1B, 6'h2C};
    exp_port = '{0, 1, 2, 0, 1, 2};
    @(negedge clk);
    clear_inputs();
    for (int p = 0; p < 3; p++) begin
      slv_req[p].ar_valid = 1'b1;
      slv_req[p].ar.id    = 4'(10 + p);
      slv_req[p].ar.addr  = 32'(32'h1000 * (p + 1));
    end
    mst_rsp.ar_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (mst_req.ar.id !== exp_id[c]) $display("FAIL ar_rr_id[%0d]: got %0h expected %0h", c, mst_req.ar.id, exp_id[c]); else n_pass++;
      n_checks++; if (slv_rsp[exp_port[c]].ar_ready !== 1'b1) $display("FAIL ar_rr_ready[%0d]: got %0b expected 1", c, slv_rsp[exp_port[c]].ar_ready); else n_pass++;
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_ar_lock();
    // pointer is back at 0 after six grants
    clear_inputs();
    slv_req[1].ar_valid = 1'b1;
    slv_req[1].ar.id    = 4'h3;
    slv_req[1].ar.addr  = 32'h2222_0000;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        slv_req[0].ar_valid = 1'b1;
        slv_req[0].ar.id    = 4'h7;
        slv_req[0].ar.addr  = 32'h0000_1111;
      end
      #1;
      n_checks++; if (mst_req.ar.id !== 6'h13) $display("FAIL ar_lock_id[%0d]: got %0h expected 13", c, mst_req.ar.id); else n_pass++;
      n_checks++; if (mst_req.ar.addr !== 32'h2222_0000) $display("FAIL ar_lock_addr[%0d]: got %0h expected 22220000", c, mst_req.ar.addr); else n_pass++;
      @(negedge clk);
    end
    mst_rsp.ar_ready = 1'b1;
    #1;
    n_checks++; if ({slv_rsp[1].ar_ready, slv_rsp[0].ar_ready} !== 2'b10) $display("FAIL ar_lock_hs: got %0b expected 10", {slv_rsp[1].ar_ready, slv_rsp[0].ar_ready}); else n_pass++;
    @(negedge clk);
    slv_req[1].ar_valid = 1'b0;
    #1;
    n_checks++; if (mst_req.ar.id !== 6'h07) $display("FAIL ar_after_lock_id: got %0h expected 07", mst_req.ar.id); else n_pass++;
    n_checks++; if (slv_rsp[0].ar_ready !== 1'b1) $display("FAIL ar_after_lock_ready: got %0b expected 1", slv_rsp[0].ar_ready); else n_pass++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_w_order();
    do_reset();
    // cycle A: port 2 AW (4 beats); port 0 W offered early
    slv_req[2].aw_valid = 1'b1;
    slv_req[2].aw.id    = 4'h2;
    slv_req[2].aw.len   = 8'd3;
    slv_req[0].w_valid  = 1'b1;
    slv_req[0].w.data   = 32'hD0D0_0000;
    slv_req[0].w.last   = 1'b1;
    mst_rsp.aw_ready    = 1'b1;
    mst_rsp.w_ready     = 1'b1;
    #1;
    n_checks++; if (mst_req.aw.id !== 6'h22) $display("FAIL w_order_aw2_id: got %0h expected 22", mst_req.aw.id); else n_pass++;
    n_checks++; if (slv_rsp[0].w_ready !== 1'b0) $display("FAIL w_order_early_p0: got %0b expected 0", slv_rsp[0].w_ready); else n_pass++;
    n_checks++; if (mst_req.w_valid !== 1'b0) $display("FAIL w_order_fallthru_valid: got %0b expected 0", mst_req.w_valid); else n_pass++;
    // cycle B: port 0 AW (1 beat); port 2 beat 0
    @(negedge clk);
    slv_req[2].aw_valid = 1'b0;
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].aw.id    = 4'h9;
    slv_req[0].aw.len   = 8'd0;
    slv_req[2].w_valid  = 1'b1;
    slv_req[2].w.data   = 32'hC200_0000;
    slv_req[2].w.last   = 1'b0;
    #1;
    n_checks++; if (mst_req.aw.id !== 6'h09) $display("FAIL w_order_aw0_id: got %0h expected 09", mst_req.aw.id); else n_pass++;
    n_checks++; if (mst_req.w.data !== 32'hC200_0000) $display("FAIL w_order_beat0: got %0h expected c2000000", mst_req.w.data); else n_pass++;
    n_checks++; if (slv_rsp[0].w_ready !== 1'b0) $display("FAIL w_order_p0_stall0: got %0b expected 0", slv_rsp[0].w_ready); else n_pass++;
    // beats 1..3 of port 2
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      slv_req[0].aw_valid = 1'b0;
      slv_req[2].w.data   = 32'(32'hC200_0000 + b);
      slv_req[2].w.last   = (b == 3);
      #1;
      n_checks++; if ({slv_rsp[2].w_ready, slv_rsp[0].w_ready} !== 2'b10) $display("FAIL w_order_beat%0d_ready: got %0b expected 10", b, {slv_rsp[2].w_ready, slv_rsp[0].w_ready}); else n_pass++;
    end
    n_checks++; if (mst_req.w.last !== 1'b1) $display("FAIL w_order_last: got %0b expected 1", mst_req.w.last); else n_pass++;
    // port 0's burst now at FIFO head
    @(negedge clk);
    slv_req[2].w_valid = 1'b0;
    #1;
    n_checks++; if (slv_rsp[0].w_ready !== 1'b1) $display("FAIL w_order_p0_ready: got %0b expected 1", slv_rsp[0].w_ready); else n_pass++;
    n_checks++; if (mst_req.w.data !== 32'hD0D0_0000) $display("FAIL w_order_p0_data: got %0h expected d0d00000", mst_req.w.data); else n_pass++;
    // FIFO drained: an extra W from port 0 must not pass
    @(negedge clk);
    #1;
    n_checks++; if ({mst_req.w_valid, slv_rsp[0].w_ready} !== 2'b00) $display("FAIL w_order_empty: got %0b expected 00", {mst_req.w_valid, slv_rsp[0].w_ready}); else n_pass++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_out_limit();
    do_reset();
    slv_req[1].aw_valid = 1'b1;
    slv_req[1].aw.id    = 4'h1;
    slv_req[1].aw.len   = 8'd0;
    mst_rsp.aw_ready    = 1'b1;
    mst_rsp.w_ready     = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (slv_rsp[1].aw_ready !== 1'b1) $display("FAIL out_limit_accept[%0d]: got %0b expected 1", c, slv_rsp[1].aw_ready); else n_pass++;
      @(negedge clk);
    end
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++; if (mst_req.aw_valid !== 1'b0) $display("FAIL out_limit_block[%0d]: got %0b expected 0", c, mst_req.aw_valid); else n_pass++;
      @(negedge clk);
    end
    slv_req[1].w_valid = 1'b1;
    slv_req[1].w.last  = 1'b1;
    #1;
    n_checks++; if ({slv_rsp[1].w_ready, mst_req.aw_valid} !== 2'b10) $display("FAIL out_limit_wlast: got %0b expected 10", {slv_rsp[1].w_ready, mst_req.aw_valid}); else n_pass++;
    @(negedge clk);
    slv_req[1].w_valid = 1'b0;
    #1;
    n_checks++; if (mst_req.aw_valid !== 1'b1) $display("FAIL out_limit_fifth: got %0b expected 1", mst_req.aw_valid); else n_pass++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_route();
    @(negedge clk);
    clear_inputs();
    mst_rsp.r_valid = 1'b1;
    mst_rsp.r.id    = 6'h35;
    mst_rsp.r.data  = 32'h1234_5678;
    mst_rsp.r.last  = 1'b1;
    #1;
    n_checks++; if (mst_req.r_ready !== 1'b1) $display("FAIL route_bad_ready: got %0b expected 1", mst_req.r_ready); else n_pass++;
    n_checks++; if (route_err !== 1'b1) $display("FAIL route_bad_err: got %0b expected 1", route_err); else n_pass++;
    n_checks++; if ({slv_rsp[2].r_valid, slv_rsp[1].r_valid, slv_rsp[0].r_valid} !== 3'b000) $display("FAIL route_bad_valid: got %0b expected 000", {slv_rsp[2].r_valid, slv_rsp[1].r_valid, slv_rsp[0].r_valid}); else n_pass++;
    @(negedge clk);
    mst_rsp.r_valid = 1'b0;
    #1;
    n_checks++; if (route_err !== 1'b0) $display("FAIL route_err_clear: got %0b expected 0", route_err); else n_pass++;
    @(negedge clk);
    mst_rsp.r_valid    = 1'b1;
    mst_rsp.r.id       = 6'h15;
    slv_req[1].r_ready = 1'b0;
    #1;
    n_checks++; if ({slv_rsp[2].r_valid, slv_rsp[1].r_valid, slv_rsp[0].r_valid} !== 3'b010) $display("FAIL route_p1_valid: got %0b expected 010", {slv_rsp[2].r_valid, slv_rsp[1].r_valid, slv_rsp[0].r_valid}); else n_pass++;
    n_checks++; if (slv_rsp[1].r.id !== 4'h5) $display("FAIL route_p1_id: got %0h expected 5", slv_rsp[1].r.id); else n_pass++;
    n_checks++; if (mst_req.r_ready !== 1'b0) $display("FAIL route_p1_ready0: got %0b expected 0", mst_req.r_ready); else n_pass++;
    @(negedge clk);
    slv_req[1].r_ready = 1'b1;
    #1;
    n_checks++; if (mst_req.r_ready !== 1'b1) $display("FAIL route_p1_ready1: got %0b expected 1", mst_req.r_ready); else n_pass++;
    @(negedge clk);
    clear_inputs();
    mst_rsp.b_valid    = 1'b1;
    mst_rsp.b.id       = 6'h07;
    slv_req[0].b_ready = 1'b1;
    #1;
    n_checks++; if ({slv_rsp[0].b_valid, slv_rsp[0].b.id} !== 5'h17) $display("FAIL route_b_p0: got %0h expected 17", {slv_rsp[0].b_valid, slv_rsp[0].b.id}); else n_pass++;
    n_checks++; if (mst_req.b_ready !== 1'b1) $display("FAIL route_b_ready: got %0b expected 1", mst_req.b_ready); else n_pass++;
    @(negedge clk);
    mst_rsp.b.id       = 6'h3F;
    slv_req[0].b_ready = 1'b0;
    #1;
    n_checks++; if ({route_err, mst_req.b_ready, slv_rsp[0].b_valid} !== 3'b110) $display("FAIL route_b_bad: got %0b expected 110", {route_err, mst_req.b_ready, slv_rsp[0].b_valid}); else n_pass++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_perf_reset();
    logic [15:0] exp_cnt;
`ifdef STD_CACHE_AXI_MUX_PERF_EN
    exp_cnt = 16'd10;
`else
    exp_cnt = 16'd0;
`endif
    do_reset();
    // one accepted AW (leaves an entry in the W FIFO), then 10 stalled cycles
    slv_req[0].aw_valid = 1'b1;
    slv_req[0].aw.id    = 4'h4;
    slv_req[0].aw.len   = 8'd0;
    mst_rsp.aw_ready    = 1'b1;
    #1;
    n_checks++; if (slv_rsp[0].aw_ready !== 1'b1) $display("FAIL perf_first_aw: got %0b expected 1", slv_rsp[0].aw_ready); else n_pass++;
    @(negedge clk);
    mst_rsp.aw_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    n_checks++; if (aw_stall_cnt[0] !== exp_cnt) $display("FAIL perf_stall_p0: got %0d expected %0d", aw_stall_cnt[0], exp_cnt); else n_pass++;
    n_checks++; if (aw_stall_cnt[1] !== 16'd0) $display("FAIL perf_stall_p1: got %0d expected 0", aw_stall_cnt[1]); else n_pass++;
    n_checks++; if (mst_req.aw_valid !== 1'b1) $display("FAIL perf_aw_held: got %0b expected 1", mst_req.aw_valid); else n_pass++;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (aw_stall_cnt[0] !== 16'd0) $display("FAIL rst_mid_cnt: got %0d expected 0", aw_stall_cnt[0]); else n_pass++;
    n_checks++; if ({mst_req.aw_valid, mst_req.w_valid} !== 2'b00) $display("FAIL rst_mid_valid: got %0b expected 00", {mst_req.aw_valid, mst_req.w_valid}); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    slv_req[0].aw_valid = 1'b0;
    slv_req[0].w_valid  = 1'b1;
    slv_req[0].w.last   = 1'b1;
    mst_rsp.w_ready     = 1'b1;
    #1;
    n_checks++; if ({mst_req.w_valid, slv_rsp[0].w_ready} !== 2'b00) $display("FAIL rst_mid_fifo: got %0b expected 00", {mst_req.w_valid, slv_rsp[0].w_ready}); else n_pass++;
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_ar_rr();
    test_ar_lock();
    test_w_order();
    test_out_limit();
    test_route();
    test_perf_reset();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
